// File: rtl/mig_app_pkg.sv
// Shared definitions for the MIG native app interface sequencer.
//   state_t : controller state encoding
//   CMD_WR / CMD_RD : MIG app_cmd opcodes
//   LINE_W / MASK_W : line data width and byte-mask width
package mig_app_pkg;

    typedef enum logic [2:0] {
        WAIT_CAL = 3'd0,
        READY    = 3'd1,
        WR       = 3'd2,
        RD       = 3'd3,
        RWAIT    = 3'd4,
        REF      = 3'd5
    } state_t;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    localparam int LINE_W = 128;
    localparam int MASK_W = 16;

endpackage

// File: rtl/mig_ref_timer.sv
// Periodic refresh scheduler.
//   mclk, mrst  : memory clock, synchronous active-high reset
//   ref_taken   : controller consumed the pending refresh (ack seen)
//   ref_wrap    : interval expires on this cycle (combinational, lets the
//                 controller withhold req_ready one cycle early)
//   ref_pend    : one refresh is waiting to be issued
//   ref_overrun : sticky, an interval expired with a refresh still pending
// REF_INTERVAL must be at least 16.
module mig_ref_timer #(
    parameter int REF_INTERVAL = 780
) (
    input  logic mclk,
    input  logic mrst,
    input  logic ref_taken,
    output logic ref_wrap,
    output logic ref_pend,
    output logic ref_overrun
);

    localparam int CW = $clog2(REF_INTERVAL);

    logic [CW-1:0] ref_cnt;

    assign ref_wrap = (ref_cnt == CW'(REF_INTERVAL - 1));

    // A wrap always (re)arms the single pending slot; if that slot was still
    // occupied and not being consumed this very cycle, a refresh was lost.
    always_ff @(posedge mclk) begin
        if (mrst) begin
            ref_cnt     <= '0;
            ref_pend    <= 1'b0;
            ref_overrun <= 1'b0;
        end else begin
            ref_cnt <= ref_wrap ? '0 : ref_cnt + CW'(1);
            if (ref_wrap) begin
                ref_pend <= 1'b1;
                if (ref_pend && !ref_taken) begin
                    ref_overrun <= 1'b1;
                end
            end else if (ref_taken) begin
                ref_pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mig_app_ctrl.sv
// Single-requester sequencer for the DDR3 MIG native app interface.
//   mclk, mrst            : memory clock, synchronous active-high reset
//   init_calib_complete   : MIG calibration done, gates all traffic
//   req_*                 : line request (valid/ready, we, addr, wdata, mask)
//   rsp_valid / rsp_rdata : read data return pulse
//   rsp_wdone             : write completion pulse
//   ref_overrun           : sticky, a refresh interval was missed
//   app_*                 : MIG command, write-data, read-data and refresh ports
// One line operation is in flight at a time; all outputs are registered.
module mig_app_ctrl
    import mig_app_pkg::*;
#(
    parameter int REF_INTERVAL = 780,
    parameter int AWIDTH       = 28
) (
    input  logic              mclk,
    input  logic              mrst,
    input  logic              init_calib_complete,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [LINE_W-1:0] req_wdata,
    input  logic [MASK_W-1:0] req_mask,
    output logic              rsp_valid,
    output logic [LINE_W-1:0] rsp_rdata,
    output logic              rsp_wdone,
    output logic              ref_overrun,
    output logic [AWIDTH-1:0] app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    input  logic              app_rdy,
    output logic [LINE_W-1:0] app_wdf_data,
    output logic [MASK_W-1:0] app_wdf_mask,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    input  logic              app_wdf_rdy,
    input  logic [LINE_W-1:0] app_rd_data,
    input  logic              app_rd_data_valid,
    input  logic              app_rd_data_end,
    output logic              app_ref_req,
    input  logic              app_ref_ack
);

    state_t state, state_nx;

    logic              ref_pend;
    logic              ref_wrap;
    logic              ref_taken;

    logic              req_ready_nx;
    logic              rsp_valid_nx;
    logic [LINE_W-1:0] rsp_rdata_nx;
    logic              rsp_wdone_nx;
    logic [AWIDTH-1:0] app_addr_nx;
    logic [2:0]        app_cmd_nx;
    logic              app_en_nx;
    logic [LINE_W-1:0] app_wdf_data_nx;
    logic [MASK_W-1:0] app_wdf_mask_nx;
    logic              app_wdf_wren_nx;
    logic              app_wdf_end_nx;
    logic              app_ref_req_nx;

    // Single-beat reads make rd_data_end redundant; the line address low
    // bits are always replaced by zero.
    logic unused_sig;
    assign unused_sig = ^{app_rd_data_end, req_addr[2:0]};

    assign ref_taken = (state == REF) && app_ref_ack;

    mig_ref_timer #(
        .REF_INTERVAL(REF_INTERVAL)
    ) u_ref_timer (
        .mclk        (mclk),
        .mrst        (mrst),
        .ref_taken   (ref_taken),
        .ref_wrap    (ref_wrap),
        .ref_pend    (ref_pend),
        .ref_overrun (ref_overrun)
    );

    // Next-state and next-output logic. Outputs that carry command payload
    // hold their value by default so they stay stable while enables are high.
    // In WR the command and write-data handshakes retire independently and
    // the state leaves only once both have dropped.
    always_comb begin
        state_nx        = state;
        rsp_valid_nx    = 1'b0;
        rsp_rdata_nx    = rsp_rdata;
        rsp_wdone_nx    = 1'b0;
        app_addr_nx     = app_addr;
        app_cmd_nx      = app_cmd;
        app_en_nx       = app_en;
        app_wdf_data_nx = app_wdf_data;
        app_wdf_mask_nx = app_wdf_mask;
        app_wdf_wren_nx = app_wdf_wren;
        app_wdf_end_nx  = app_wdf_end;
        app_ref_req_nx  = 1'b0;

        case (state)
            WAIT_CAL: begin
                if (init_calib_complete) begin
                    state_nx = READY;
                end
            end
            READY: begin
                if (!init_calib_complete) begin
                    state_nx = WAIT_CAL;
                end else if (ref_pend) begin
                    state_nx       = REF;
                    app_ref_req_nx = 1'b1;
                end else if (req_valid && req_ready) begin
                    app_en_nx   = 1'b1;
                    app_addr_nx = {req_addr[AWIDTH-1:3], 3'b000};
                    if (req_we) begin
                        state_nx        = WR;
                        app_cmd_nx      = CMD_WR;
                        app_wdf_data_nx = req_wdata;
                        app_wdf_mask_nx = req_mask;
                        app_wdf_wren_nx = 1'b1;
                        app_wdf_end_nx  = 1'b1;
                    end else begin
                        state_nx   = RD;
                        app_cmd_nx = CMD_RD;
                    end
                end
            end
            WR: begin
                if (app_en && app_rdy) begin
                    app_en_nx = 1'b0;
                end
                if (app_wdf_wren && app_wdf_rdy) begin
                    app_wdf_wren_nx = 1'b0;
                    app_wdf_end_nx  = 1'b0;
                end
                if (!app_en_nx && !app_wdf_wren_nx) begin
                    state_nx     = READY;
                    rsp_wdone_nx = 1'b1;
                end
            end
            RD: begin
                if (app_rdy) begin
                    app_en_nx = 1'b0;
                    state_nx  = RWAIT;
                end
            end
            RWAIT: begin
                if (app_rd_data_valid) begin
                    rsp_rdata_nx = app_rd_data;
                    rsp_valid_nx = 1'b1;
                    state_nx     = READY;
                end
            end
            REF: begin
                if (app_ref_ack) begin
                    state_nx = READY;
                end
            end
            default: begin
                state_nx = WAIT_CAL;
            end
        endcase

        // req_ready is registered, so it is only raised for a READY cycle
        // that follows a READY cycle, and withheld when a refresh is pending
        // or about to become pending, so a shown ready is never overridden.
        req_ready_nx = (state == READY) && (state_nx == READY) &&
                       !ref_pend && !ref_wrap && init_calib_complete;
    end

    // State and registered outputs.
    always_ff @(posedge mclk) begin
        if (mrst) begin
            state        <= WAIT_CAL;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_wdone    <= 1'b0;
            app_addr     <= '0;
            app_cmd      <= 3'b000;
            app_en       <= 1'b0;
            app_wdf_data <= '0;
            app_wdf_mask <= '0;
            app_wdf_wren <= 1'b0;
            app_wdf_end  <= 1'b0;
            app_ref_req  <= 1'b0;
        end else begin
            state        <= state_nx;
            req_ready    <= req_ready_nx;
            rsp_valid    <= rsp_valid_nx;
            rsp_rdata    <= rsp_rdata_nx;
            rsp_wdone    <= rsp_wdone_nx;
            app_addr     <= app_addr_nx;
            app_cmd      <= app_cmd_nx;
            app_en       <= app_en_nx;
            app_wdf_data <= app_wdf_data_nx;
            app_wdf_mask <= app_wdf_mask_nx;
            app_wdf_wren <= app_wdf_wren_nx;
            app_wdf_end  <= app_wdf_end_nx;
            app_ref_req  <= app_ref_req_nx;
        end
    end

endmodule

// File: tb/tb_mig_app_ctrl.sv
// Directed testbench for mig_app_ctrl.
// dut uses the default refresh interval so refresh stays out of the way of
// the latency checks; dut_r shares the inputs and uses a 16-cycle interval
// for the refresh scheduling and overrun checks.
module tb_mig_app_ctrl;
    import mig_app_pkg::*;

    localparam logic [127:0] DATA_W2 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] DATA_W3 = 128'hDEADBEEF00112233445566778899AABB;
    localparam logic [127:0] DATA_A5 = {16{8'hA5}};
    localparam logic [127:0] DATA_R5 = 128'h5555AAAA5555AAAA5555AAAA5555AAAA;

    logic         mclk = 1'b0;
    logic         mrst;
    logic         init_calib_complete;
    logic         req_valid;
    logic         req_we;
    logic [27:0]  req_addr;
    logic [127:0] req_wdata;
    logic [15:0]  req_mask;
    logic         app_rdy;
    logic         app_wdf_rdy;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         app_ref_ack;

    logic         req_ready, rsp_valid, rsp_wdone, ref_overrun;
    logic [127:0] rsp_rdata, app_wdf_data;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en, app_wdf_wren, app_wdf_end, app_ref_req;
    logic [15:0]  app_wdf_mask;

    logic         r_req_ready, r_rsp_valid, r_rsp_wdone, r_ref_overrun;
    logic [127:0] r_rsp_rdata, r_app_wdf_data;
    logic [27:0]  r_app_addr;
    logic [2:0]   r_app_cmd;
    logic         r_app_en, r_app_wdf_wren, r_app_wdf_end, r_app_ref_req;
    logic [15:0]  r_app_wdf_mask;

    logic [27:0]  mem_addr;
    logic [127:0] mem_data;

    int total = 0;
    int bad   = 0;

    always #5 mclk = ~mclk;

    mig_app_ctrl #(.REF_INTERVAL(780), .AWIDTH(28)) dut (
        .mclk(mclk), .mrst(mrst), .init_calib_complete(init_calib_complete),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_wdone(rsp_wdone),
        .ref_overrun(ref_overrun), .app_addr(app_addr), .app_cmd(app_cmd),
        .app_en(app_en), .app_rdy(app_rdy), .app_wdf_data(app_wdf_data),
        .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data_end(app_rd_data_valid), .app_ref_req(app_ref_req),
        .app_ref_ack(app_ref_ack)
    );

    mig_app_ctrl #(.REF_INTERVAL(16), .AWIDTH(28)) dut_r (
        .mclk(mclk), .mrst(mrst), .init_calib_complete(init_calib_complete),
        .req_valid(req_valid), .req_ready(r_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
        .rsp_valid(r_rsp_valid), .rsp_rdata(r_rsp_rdata), .rsp_wdone(r_rsp_wdone),
        .ref_overrun(r_ref_overrun), .app_addr(r_app_addr), .app_cmd(r_app_cmd),
        .app_en(r_app_en), .app_rdy(app_rdy), .app_wdf_data(r_app_wdf_data),
        .app_wdf_mask(r_app_wdf_mask), .app_wdf_wren(r_app_wdf_wren),
        .app_wdf_end(r_app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data_end(app_rd_data_valid), .app_ref_req(r_app_ref_req),
        .app_ref_ack(app_ref_ack)
    );

    // Single-line memory standing in for dummy_mig: remembers the last
    // accepted write address and write data.
    always @(posedge mclk) begin
        if (app_en && app_rdy && app_cmd == CMD_WR) begin
            mem_addr <= app_addr;
        end
        if (app_wdf_wren && app_wdf_rdy) begin
            mem_data <= app_wdf_data;
        end
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [127:0] got,
                               input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    // Presents one request to dut once it shows ready (bounded wait), holds it
    // for the accepting edge and returns in the first cycle after acceptance.
    task automatic applyStimulus(input logic we, input logic [27:0] addr,
                                 input logic [127:0] data, input logic [15:0] mask);
        int waitCnt = 0;
        while (!req_ready && waitCnt < 20) begin
            tick();
            waitCnt++;
        end
        if (!req_ready) checkOutput("req_ready_timeout", {127'd0, req_ready}, 128'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        req_mask  = mask;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic seen;

        mrst = 1'b1; init_calib_complete = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_mask = '0; app_rdy = 1'b1;
        app_wdf_rdy = 1'b1; app_rd_data = '0; app_rd_data_valid = 1'b0;
        app_ref_ack = 1'b0;

        // Reset and calibration gating
        tick(); tick();
        checkOutput("rst_req_ready", {127'd0, req_ready}, 128'd0);
        checkOutput("rst_app_en", {127'd0, app_en}, 128'd0);
        checkOutput("rst_app_addr", {100'd0, app_addr}, 128'd0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 128'd0);
        checkOutput("rst_overrun", {127'd0, ref_overrun}, 128'd0);
        mrst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (req_ready || app_en) seen = 1'b1;
        end
        checkOutput("cal_low_idle", {127'd0, seen}, 128'd0);
        init_calib_complete = 1'b1;
        tick();
        checkOutput("ready_entry_state", 128'(dut.state), 128'(READY));
        checkOutput("ready_entry_req_ready", {127'd0, req_ready}, 128'd0);
        tick();
        checkOutput("ready_next_req_ready", {127'd0, req_ready}, 128'd1);

        // Write at full MIG readiness, then read it back
        applyStimulus(1'b1, 28'h0000010, DATA_W2, 16'h0000);
        checkOutput("w2_en_wren", {126'd0, app_en, app_wdf_wren}, 128'd3);
        checkOutput("w2_cmd", {125'd0, app_cmd}, 128'(CMD_WR));
        checkOutput("w2_addr", {100'd0, app_addr}, 128'h10);
        checkOutput("w2_data", app_wdf_data, DATA_W2);
        checkOutput("w2_req_ready", {127'd0, req_ready}, 128'd0);
        tick();
        checkOutput("w2_wdone", {127'd0, rsp_wdone}, 128'd1);
        checkOutput("w2_drop", {126'd0, app_en, app_wdf_wren}, 128'd0);
        tick();
        checkOutput("w2_wdone_pulse", {127'd0, rsp_wdone}, 128'd0);
        applyStimulus(1'b0, 28'h0000010, '0, '0);
        checkOutput("r2_cmd", {124'd0, app_en, app_cmd}, 128'h9);
        tick();
        checkOutput("r2_en_drop", {127'd0, app_en}, 128'd0);
        checkOutput("r2_mem_addr", {100'd0, mem_addr}, 128'h10);
        app_rd_data = mem_data; app_rd_data_valid = 1'b1;
        tick();
        app_rd_data_valid = 1'b0;
        checkOutput("r2_rsp_valid", {127'd0, rsp_valid}, 128'd1);
        checkOutput("r2_rsp_rdata", rsp_rdata, DATA_W2);

        // Write with the command port stalled for three cycles
        app_rdy = 1'b0;
        applyStimulus(1'b1, 28'h0000040, DATA_W3, 16'h00F0);
        checkOutput("w3_mask", {112'd0, app_wdf_mask}, 128'h00F0);
        checkOutput("w3_en_wren", {126'd0, app_en, app_wdf_wren}, 128'd3);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("w3_hold", {98'd0, app_en, app_wdf_wren, rsp_wdone, app_addr},
                        {98'd0, 1'b1, 1'b0, 1'b0, 28'h0000040});
        end
        app_rdy = 1'b1;
        tick();
        checkOutput("w3_wdone", {126'd0, rsp_wdone, app_en}, 128'd2);
        checkOutput("w3_mem", mem_data, DATA_W3);

        // Read with unaligned address and delayed return
        applyStimulus(1'b0, 28'h0000027, '0, '0);
        checkOutput("r4_addr", {100'd0, app_addr}, 128'h20);
        checkOutput("r4_cmd", {124'd0, app_en, app_cmd}, 128'h9);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid) seen = 1'b1;
        end
        checkOutput("r4_no_early_valid", {127'd0, seen}, 128'd0);
        app_rd_data = DATA_A5; app_rd_data_valid = 1'b1;
        tick();
        app_rd_data_valid = 1'b0;
        checkOutput("r4_rsp", {rsp_rdata[126:0], rsp_valid}, {DATA_A5[126:0], 1'b1});
        tick();
        checkOutput("r4_pulse", {127'd0, rsp_valid}, 128'd0);

        // Reset while waiting for read data
        applyStimulus(1'b0, 28'h0000080, '0, '0);
        tick();
        checkOutput("r6_in_rwait", 128'(dut.state), 128'(RWAIT));
        mrst = 1'b1;
        tick();
        mrst = 1'b0;
        checkOutput("r6_state", 128'(dut.state), 128'(WAIT_CAL));
        checkOutput("r6_rdata_clr", rsp_rdata, 128'd0);
        checkOutput("r6_addr_clr", {99'd0, app_en, app_addr}, 128'd0);
        app_rd_data = {128{1'b1}}; app_rd_data_valid = 1'b1;
        tick();
        app_rd_data_valid = 1'b0;
        checkOutput("r6_no_rsp", {127'd0, rsp_valid}, 128'd0);
        checkOutput("r6_rdata_kept0", rsp_rdata, 128'd0);

        // Refresh behind a read, then overrun (dut_r, interval 16)
        mrst = 1'b1;
        tick(); tick();
        mrst = 1'b0;
        tick();
        checkOutput("r5_first_ready", {127'd0, r_req_ready}, 128'd0);
        tick();
        checkOutput("r5_ready", {127'd0, r_req_ready}, 128'd1);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 28'h0000100;
        tick();
        req_valid = 1'b0;
        checkOutput("r5_rd_cmd", {124'd0, r_app_en, r_app_cmd}, 128'h9);
        for (int i = 0; i < 17; i++) tick();
        checkOutput("r5_still_rwait", 128'(dut_r.state), 128'(RWAIT));
        app_rd_data = DATA_R5; app_rd_data_valid = 1'b1;
        tick();
        app_rd_data_valid = 1'b0;
        checkOutput("r5_read_first", {r_rsp_rdata[125:0], r_rsp_valid, r_app_ref_req},
                    {DATA_R5[125:0], 1'b1, 1'b0});
        checkOutput("r5_no_overrun_yet", {127'd0, r_ref_overrun}, 128'd0);
        tick();
        checkOutput("r5_ref_req", {126'd0, r_app_ref_req, r_req_ready}, 128'd2);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (r_app_ref_req || r_req_ready) seen = 1'b1;
        end
        checkOutput("r5_ref_wait_quiet", {127'd0, seen}, 128'd0);
        checkOutput("r5_overrun", {127'd0, r_ref_overrun}, 128'd1);
        app_ref_ack = 1'b1;
        tick();
        app_ref_ack = 1'b0;
        tick();
        checkOutput("r5_ready_after_ack", {126'd0, r_req_ready, r_ref_overrun}, 128'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
